// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared types and constants for the miniCPU front end.
//             - pc_state_t     : program-counter sequencer states
//             - XLEN_DEFAULT   : default datapath width
//             - RESET_VECTOR_DEFAULT : default boot address
//             - ALIGN_LOW_MASK : low address bits that must be zero for a
//                                word-aligned instruction fetch
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

   localparam int          XLEN_DEFAULT         = 32;
   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam logic [1:0]  ALIGN_LOW_MASK       = 2'b11;

   typedef enum logic [1:0] {
      PC_BOOT = 2'd0,
      PC_RUN  = 2'd1,
      PC_HALT = 2'd2
   } pc_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_boot_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : pc_boot_cnt
//  Purpose  : Counts cycles since reset release and flags the last boot cycle.
//             The count saturates on its terminal value, so done stays high
//             until the next reset. Only meaningful for BOOT_DELAY >= 1.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset (count restarts at 0)
//             done  - high while count == BOOT_DELAY-1 (last boot cycle)
//  Revision : 1.0  initial release
// ============================================================================
module pc_boot_cnt #(
   parameter int BOOT_DELAY = 1
) (
   input  logic clk,
   input  logic rst_n,
   output logic done
);

   localparam int            CW   = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(BOOT_DELAY - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!done) begin
         count <= count + CW'(1);
      end
   end

   assign done = (count == LAST);

endmodule : pc_boot_cnt
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pc_gen
//  Purpose  : Fetch-stage program counter. Holds RESET_VECTOR for BOOT_DELAY
//             cycles after reset, then advances by INC each cycle. Next-PC
//             priority in RUN: trap > redirect > halt > stall > sequential.
//             HALT parks the PC until a trap or redirect arrives.
//  Option   : PC_ALIGN_CHECK_EN - misaligned redirects are dropped and
//             reported on misalign_o / misalign_addr_o instead of masked.
//  Ports    : clk, rst_n (async, active-low)
//             stall_i, halt_i, redirect_valid_i/redirect_pc_i,
//             trap_valid_i/trap_pc_i   - control and redirect inputs
//             pc_o          - registered fetch PC
//             pc_next_o     - value pc_o takes at the next edge
//             fetch_valid_o - pc_o is a valid fetch this cycle
//             boot_done_o   - sticky, set on entry to RUN
//             misalign_o, misalign_addr_o (option only)
//  Revision : 1.0  initial release
// ============================================================================
module pc_gen
   import cpu_pkg::*;
#(
   parameter int               XLEN         = XLEN_DEFAULT,
   parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
   parameter int               BOOT_DELAY   = 1,
   parameter int               INC          = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            halt_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            trap_valid_i,
   input  logic [XLEN-1:0] trap_pc_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_next_o,
   output logic            fetch_valid_o,
   output logic            boot_done_o
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic            misalign_o,
   output logic [XLEN-1:0] misalign_addr_o
`endif
);

   localparam logic [XLEN-1:0] ALIGN_MASK    = ~XLEN'(ALIGN_LOW_MASK);
   localparam logic [XLEN-1:0] INC_X         = XLEN'(INC);
   localparam pc_state_t       STATE_RST     = (BOOT_DELAY == 0) ? PC_RUN : PC_BOOT;
   localparam logic            BOOT_DONE_RST = (BOOT_DELAY == 0);

   pc_state_t       state;
   pc_state_t       state_next;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] trap_tgt;
   logic [XLEN-1:0] redir_tgt;
   logic            redir_ok;
   logic            mis_event;
   logic            boot_last;

   generate
      if (BOOT_DELAY > 0) begin : g_boot_cnt
         pc_boot_cnt #(
            .BOOT_DELAY (BOOT_DELAY)
         ) u_boot_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .done  (boot_last)
         );
      end else begin : g_no_boot
         assign boot_last = 1'b1;
      end
   endgenerate

   assign trap_tgt = trap_pc_i & ALIGN_MASK;

`ifdef PC_ALIGN_CHECK_EN
   // Misaligned targets are rejected, not silently rounded down.
   assign redir_tgt = redirect_pc_i;
   assign redir_ok  = (redirect_pc_i[1:0] == 2'b00);
`else
   assign redir_tgt = redirect_pc_i & ALIGN_MASK;
   assign redir_ok  = 1'b1;
`endif

   always_comb begin
      pc_next    = pc_o;
      state_next = state;
      mis_event  = 1'b0;
      case (state)
         PC_BOOT: begin
            if (boot_last) begin
               state_next = PC_RUN;
            end
         end
         PC_RUN: begin
            if (trap_valid_i) begin
               pc_next = trap_tgt;
            end else if (redirect_valid_i) begin
               // A rejected redirect still outranks halt/stall: PC just holds.
               if (redir_ok) begin
                  pc_next = redir_tgt;
               end else begin
                  mis_event = 1'b1;
               end
            end else if (halt_i) begin
               state_next = PC_HALT;
            end else if (!stall_i) begin
               pc_next = pc_o + INC_X;
            end
         end
         PC_HALT: begin
            if (trap_valid_i) begin
               pc_next    = trap_tgt;
               state_next = PC_RUN;
            end else if (redirect_valid_i) begin
               if (redir_ok) begin
                  pc_next    = redir_tgt;
                  state_next = PC_RUN;
               end else begin
                  mis_event = 1'b1;
               end
            end
         end
         default: begin
            pc_next    = RESET_VECTOR;
            state_next = STATE_RST;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= STATE_RST;
         pc_o        <= RESET_VECTOR;
         boot_done_o <= BOOT_DONE_RST;
      end else begin
         state       <= state_next;
         pc_o        <= pc_next;
         boot_done_o <= boot_done_o | (state_next == PC_RUN);
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_o      <= 1'b0;
         misalign_addr_o <= '0;
      end else begin
         misalign_o <= mis_event;
         if (mis_event) begin
            misalign_addr_o <= redirect_pc_i;
         end
      end
   end
`else
   logic unused_mis;
   assign unused_mis = mis_event;
`endif

   assign pc_next_o = pc_next;
   // Gated by rst_n so a zero boot delay still reports no fetch under reset.
   assign fetch_valid_o = rst_n && (state == PC_RUN) && !stall_i;

endmodule : pc_gen
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_gen
//  Purpose  : Self-checking bench for pc_gen. Instance A uses BOOT_DELAY=1,
//             instance B BOOT_DELAY=3; both boot from 0x100. A vector table
//             drives RUN/HALT behaviour on A; boot, misalign and reset
//             corner cases are hand-written sequences.
//  Option   : PC_ALIGN_CHECK_EN - enables the misalign port checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, halt, rv, tv;
   logic [31:0] rpc, tpc;

   logic [31:0] pc_a, next_a, pc_b, next_b;
   logic        fv_a, bd_a, fv_b, bd_b;
`ifdef PC_ALIGN_CHECK_EN
   logic        ma_a, ma_b;
   logic [31:0] maddr_a, maddr_b;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .BOOT_DELAY(1), .INC(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .stall_i(stall), .halt_i(halt),
      .redirect_valid_i(rv), .redirect_pc_i(rpc),
      .trap_valid_i(tv), .trap_pc_i(tpc),
      .pc_o(pc_a), .pc_next_o(next_a), .fetch_valid_o(fv_a), .boot_done_o(bd_a)
`ifdef PC_ALIGN_CHECK_EN
      , .misalign_o(ma_a), .misalign_addr_o(maddr_a)
`endif
   );

   pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .BOOT_DELAY(3), .INC(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .stall_i(stall), .halt_i(halt),
      .redirect_valid_i(rv), .redirect_pc_i(rpc),
      .trap_valid_i(tv), .trap_pc_i(tpc),
      .pc_o(pc_b), .pc_next_o(next_b), .fetch_valid_o(fv_b), .boot_done_o(bd_b)
`ifdef PC_ALIGN_CHECK_EN
      , .misalign_o(ma_b), .misalign_addr_o(maddr_b)
`endif
   );

   typedef struct {
      logic        stall;
      logic        halt;
      logic        rv;
      logic [31:0] rpc;
      logic        tv;
      logic [31:0] tpc;
      logic [31:0] exp_next;
      logic        exp_fv;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      stall = 1'b0; halt = 1'b0; rv = 1'b0; tv = 1'b0;
      rpc = 32'h0; tpc = 32'h0;
   endtask

   task automatic add(input logic s, input logic h, input logic r, input logic [31:0] rp,
                      input logic t, input logic [31:0] tp, input logic [31:0] en,
                      input logic ef, input logic [31:0] ep);
      vec_t v;
      v.stall = s; v.halt = h; v.rv = r; v.rpc = rp; v.tv = t; v.tpc = tp;
      v.exp_next = en; v.exp_fv = ef; v.exp_pc = ep;
      vecs.push_back(v);
   endtask

   initial begin
      // Table starts with A in RUN at 0x108.
      //   s  h  r  rpc           t  tpc           next          fv pc
      add(0, 0, 1, 32'h200,      0, 32'h0,      32'h200,      1, 32'h200);      // redirect
      add(1, 0, 1, 32'h400,      0, 32'h0,      32'h400,      0, 32'h400);      // redirect beats stall
      add(0, 0, 1, 32'h123C,     1, 32'h800,    32'h800,      1, 32'h800);      // trap beats redirect
      add(1, 0, 0, 32'h0,        0, 32'h0,      32'h800,      0, 32'h800);      // stall holds
      add(0, 0, 0, 32'h0,        0, 32'h0,      32'h804,      1, 32'h804);      // sequential
      add(0, 0, 0, 32'h0,        1, 32'h903,    32'h900,      1, 32'h900);      // trap target masked
      add(0, 0, 1, 32'h300,      0, 32'h0,      32'h300,      1, 32'h300);
      add(0, 1, 0, 32'h0,        0, 32'h0,      32'h300,      1, 32'h300);      // halt request
      add(1, 0, 0, 32'h0,        0, 32'h0,      32'h300,      0, 32'h300);      // HALT: stall no effect
      add(0, 1, 0, 32'h0,        0, 32'h0,      32'h300,      0, 32'h300);
      add(0, 0, 0, 32'h0,        0, 32'h0,      32'h300,      0, 32'h300);
      add(0, 0, 0, 32'h0,        0, 32'h0,      32'h300,      0, 32'h300);
      add(0, 0, 1, 32'h40,       0, 32'h0,      32'h40,       0, 32'h40);       // redirect leaves HALT
      add(0, 0, 0, 32'h0,        0, 32'h0,      32'h44,       1, 32'h44);
      add(0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,      32'hFFFFFFFC, 1, 32'hFFFFFFFC);
      add(0, 0, 0, 32'h0,        0, 32'h0,      32'h0,        1, 32'h0);        // wrap
      add(0, 1, 1, 32'h500,      0, 32'h0,      32'h500,      1, 32'h500);      // redirect beats halt
      add(0, 0, 0, 32'h0,        0, 32'h0,      32'h504,      1, 32'h504);      // still RUN
      add(0, 1, 0, 32'h0,        0, 32'h0,      32'h504,      1, 32'h504);
      add(0, 0, 0, 32'h0,        1, 32'h61,     32'h60,       0, 32'h60);       // trap leaves HALT
      add(0, 0, 0, 32'h0,        0, 32'h0,      32'h64,       1, 32'h64);
      add(0, 0, 1, 32'h10,       0, 32'h0,      32'h10,       1, 32'h10);

      clear_in();
      rst_n = 1'b0;
      #12;
      chk("rst pc_a", pc_a, 32'h100);
      chk("rst fv_a", {31'b0, fv_a}, 32'h0);
      chk("rst bd_a", {31'b0, bd_a}, 32'h0);
      chk("rst pc_b", pc_b, 32'h100);
      chk("rst bd_b", {31'b0, bd_b}, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
      chk("rst ma_a", {31'b0, ma_a}, 32'h0);
      chk("rst maddr_a", maddr_a, 32'h0);
`endif

      // Boot of A: 0x100, 0x100, 0x104, 0x108.
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("boot0 pc", pc_a, 32'h100);
      chk("boot0 fv", {31'b0, fv_a}, 32'h0);
      chk("boot0 next", next_a, 32'h100);
      step();
      chk("boot1 pc", pc_a, 32'h100);
      chk("boot1 fv", {31'b0, fv_a}, 32'h1);
      chk("boot1 bd", {31'b0, bd_a}, 32'h1);
      chk("boot1 next", next_a, 32'h104);
      step();
      chk("boot2 pc", pc_a, 32'h104);
      step();
      chk("boot3 pc", pc_a, 32'h108);

      foreach (vecs[i]) begin
         stall = vecs[i].stall; halt = vecs[i].halt;
         rv = vecs[i].rv; rpc = vecs[i].rpc;
         tv = vecs[i].tv; tpc = vecs[i].tpc;
         #1;
         chk($sformatf("vec%0d next", i), next_a, vecs[i].exp_next);
         chk($sformatf("vec%0d fv", i), {31'b0, fv_a}, {31'b0, vecs[i].exp_fv});
         step();
         chk($sformatf("vec%0d pc", i), pc_a, vecs[i].exp_pc);
      end
      clear_in();

      // Misaligned redirect at pc 0x10.
      rv = 1'b1; rpc = 32'h402;
      #1;
`ifdef PC_ALIGN_CHECK_EN
      chk("mis next", next_a, 32'h10);
`else
      chk("mis next", next_a, 32'h400);
`endif
      step();
      clear_in();
`ifdef PC_ALIGN_CHECK_EN
      chk("mis pc", pc_a, 32'h10);
      chk("mis flag", {31'b0, ma_a}, 32'h1);
      chk("mis addr", maddr_a, 32'h402);
`else
      chk("mis pc", pc_a, 32'h400);
`endif
      step();
`ifdef PC_ALIGN_CHECK_EN
      chk("mis pc+1", pc_a, 32'h14);
      chk("mis flag+1", {31'b0, ma_a}, 32'h0);
      chk("mis addr+1", maddr_a, 32'h402);
`else
      chk("mis pc+1", pc_a, 32'h404);
`endif
      // Trap alongside a misaligned redirect: trap wins, nothing reported.
      tv = 1'b1; tpc = 32'hA00; rv = 1'b1; rpc = 32'h5;
      step();
      clear_in();
      chk("trap+mis pc", pc_a, 32'hA00);
`ifdef PC_ALIGN_CHECK_EN
      chk("trap+mis flag", {31'b0, ma_a}, 32'h0);
      chk("trap+mis addr", maddr_a, 32'h402);
`endif

      // Asynchronous reset mid-run.
      rst_n = 1'b0;
      #1;
      chk("arst pc", pc_a, 32'h100);
      chk("arst bd", {31'b0, bd_a}, 32'h0);
      chk("arst fv", {31'b0, fv_a}, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
      chk("arst maddr", maddr_a, 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("arst boot1 pc", pc_a, 32'h100);
      chk("arst boot1 bd", {31'b0, bd_a}, 32'h1);
      step();
      chk("arst boot2 pc", pc_a, 32'h104);

      // Instance B: BOOT_DELAY=3 ignores trap/redirect/halt while booting.
      rst_n = 1'b0;
      #2;
      chk("b rst pc", pc_b, 32'h100);
      @(negedge clk);
      rst_n = 1'b1;
      tv = 1'b1; tpc = 32'h800; rv = 1'b1; rpc = 32'h400; halt = 1'b1;
      step();
      chk("b e1 pc", pc_b, 32'h100);
      chk("b e1 bd", {31'b0, bd_b}, 32'h0);
      step();
      chk("b e2 pc", pc_b, 32'h100);
      chk("b e2 bd", {31'b0, bd_b}, 32'h0);
      chk("b e2 fv", {31'b0, fv_b}, 32'h0);
      step();
      clear_in();
      #1;
      chk("b e3 pc", pc_b, 32'h100);
      chk("b e3 bd", {31'b0, bd_b}, 32'h1);
      chk("b e3 fv", {31'b0, fv_b}, 32'h1);
      chk("b e3 next", next_b, 32'h104);
      step();
      chk("b e4 pc", pc_b, 32'h104);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_pc_gen
`default_nettype wire

// File: doc/pc_gen.md
# pc_gen

Parameterised program-counter generator for the miniCPU fetch stage. Holds the PC at a reset vector for a programmable boot delay, then advances sequentially. It accepts stalls, halts, branch/jump redirects and trap redirects with fixed priority. It sits between the fetch address port of instruction memory and the redirect sources in EX and the trap/CSR logic.

## Interface
- XLEN, 32: PC width in bits, ≥ 8
- RESET_VECTOR, 0: PC value loaded on reset, aligned to 4
- BOOT_DELAY, 1: cycles PC is held at RESET_VECTOR after reset release; 0 allowed
- INC, 4: sequential increment
---
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  hold PC (downstream not ready)
- halt_i  in  1  enter HALT (e.g. ebreak/wfi)
- redirect_valid_i  in  1  branch/jump taken
- redirect_pc_i  in  XLEN  branch/jump target
- trap_valid_i  in  1  trap/exception entry or mret
- trap_pc_i  in  XLEN  trap target
- pc_o  out  XLEN  current fetch PC (registered)
- pc_next_o  out  XLEN  value pc_o takes at the next edge (combinational)
- fetch_valid_o  out  1  pc_o is a valid fetch address this cycle
- boot_done_o  out  1  BOOT phase finished (registered, sticky until reset)
- misalign_o, misalign_addr_o  out  1/XLEN  only with PC_ALIGN_CHECK_EN

## Operation
- States: BOOT, RUN, HALT. Reset enters BOOT, or RUN if BOOT_DELAY == 0.
- BOOT: pc_o = RESET_VECTOR. Boot counter ($clog2(BOOT_DELAY+1) bits) increments each cycle. When the count reaches BOOT_DELAY-1, go to RUN. All inputs are ignored, including trap, redirect, stall and halt.
- RUN: next-PC priority is trap > redirect > halt > stall > sequential.
  - trap_valid_i: pc <= trap_pc_i & ~3.
  - redirect_valid_i: pc <= redirect target.
  - halt_i: pc holds; go to HALT.
  - stall_i: pc holds.
  - Otherwise: pc <= pc + INC, truncated to XLEN, so it wraps modulo 2^XLEN.
  - A trap or redirect overrides a simultaneous stall or halt. The redirect is taken and the block stays in RUN.
- HALT: pc holds and fetch_valid_o = 0. trap_valid_i or redirect_valid_i loads the target and returns to RUN. stall_i and halt_i have no effect.
- fetch_valid_o = (state == RUN) && !stall_i.
- pc_next_o always equals the registered value pc_o will take at the next edge, including in BOOT and HALT.

## Timing
- Reset values:
  - pc_o = RESET_VECTOR
  - fetch_valid_o = 0
  - boot_done_o = (BOOT_DELAY == 0)
  - misalign_o = 0
  - misalign_addr_o = 0
- Reset asserted mid-operation returns the block to reset values asynchronously. The boot delay restarts on release.
- First sequential advance: pc_o = RESET_VECTOR + INC appears BOOT_DELAY+1 rising edges after rst_n release, with no stall. BOOT_DELAY = 1 gives one extra hold cycle of RESET_VECTOR.
- Redirect latency is 1 cycle. An input sampled at edge N is visible on pc_o after edge N.
- boot_done_o rises on the same edge the state enters RUN.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc_i[1:0] != 0 is dropped and the PC holds.
  - misalign_o pulses high for 1 cycle, registered on the next edge.
  - misalign_addr_o latches the offending target and holds it until the next misalign event.
  - A trap in the same cycle wins, and no misalign is reported.
- Not defined: redirect target is masked with ~3. Ports misalign_o and misalign_addr_o are absent.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum pc_state_t {PC_BOOT, PC_RUN, PC_HALT}
  - XLEN_DEFAULT
  - RESET_VECTOR_DEFAULT
  - the alignment mask constant
- Optional sub-module `pc_boot_cnt`: the BOOT_DELAY counter with a done output. All other logic stays in pc_gen.

## Test plan
- Reset release, BOOT_DELAY=1, RESET_VECTOR=0x100, no stall -> pc_o sequence 0x100, 0x100, 0x104, 0x108. fetch_valid_o goes 0, 1, 1, 1.
- BOOT_DELAY=3, trap_valid_i pulsed in BOOT -> ignored. pc_o first reaches 0x104 on the 4th edge after release.
- RUN at 0x200: stall_i and redirect_valid_i (0x400) together -> pc_o=0x400 next cycle. trap_valid_i (0x800) plus redirect in the same cycle -> 0x800.
- halt_i at pc 0x300 -> pc holds at 0x300 and fetch_valid_o=0 for 5 cycles. redirect to 0x40 -> pc_o=0x40, RUN resumes, next 0x44.
- pc_o=0xFFFF_FFFC, sequential -> 0x0000_0000 (wrap). rst_n asserted mid-run -> pc_o=RESET_VECTOR immediately and boot_done_o=0.
- PC_ALIGN_CHECK_EN, redirect to 0x402 at pc 0x10 -> pc_o holds 0x10, misalign_o=1 for one cycle, misalign_addr_o=0x402. Without the macro -> pc_o=0x400.
